// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares the single main-memory port between the I-cache refill path and
// the D-cache refill/write-back path. One line-sized transaction is in
// flight at a time. The memory-side signals are held stable until
// mem_ready arrives. The winner then receives its data and a one-cycle
// ready pulse. A single RECOVER cycle follows before the next grant.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN - when defined, simultaneous D and I requests are
//                        granted to the side that did not win last time.
//                        When undefined, D always wins over I.
//
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   i_read, i_addr             I-cache line read request (held until i_ready)
//   i_ready, i_rdata           I completion pulse and returned line
//   d_read, d_write            D-cache line read / write-back request
//   d_addr, d_wdata            D-cache line address and write-back data
//   d_ready, d_rdata           D completion pulse and returned line
//   mem_read, mem_write        memory strobes (at most one high)
//   mem_addr, mem_wdata        memory line address and write data
//   mem_ready, mem_rdata       memory completion and read data
//   grant_d                    D owns the port (SERVE_D, or RECOVER after D)
//   busy                       arbiter is not IDLE
//
// All outputs are registered.

`timescale 1ns/1ps

module mem_port_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              grant_d,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RECOVER = 2'd3
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              i_ready_q, i_ready_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic              d_ready_q, d_ready_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              grant_d_q, grant_d_d;
    logic              busy_q, busy_d;

    logic              d_req;
    logic              pick_d;

    // Arbitration decision, only acted on in IDLE. A lone request always
    // wins; the policy only matters when both sides are pending.
    always_comb begin
        d_req = d_read | d_write;
`ifdef ARB_ROUND_ROBIN_EN
        if (d_req && i_read) begin
            pick_d = (last_grant_q != GRANT_D);
        end else begin
            pick_d = d_req;
        end
`else
        pick_d = d_req;
`endif
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        i_ready_d    = i_ready_q;
        i_rdata_d    = i_rdata_q;
        d_ready_d    = d_ready_q;
        d_rdata_d    = d_rdata_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    // A simultaneous read+write is treated as a write.
                    state_d      = SERVE_D;
                    last_grant_d = GRANT_D;
                    mem_addr_d   = d_addr;
                    mem_write_d  = d_write;
                    mem_read_d   = ~d_write;
                    mem_wdata_d  = d_write ? d_wdata : '0;
                end else if (i_read) begin
                    state_d      = SERVE_I;
                    last_grant_d = GRANT_I;
                    mem_addr_d   = i_addr;
                    mem_write_d  = 1'b0;
                    mem_read_d   = 1'b1;
                    mem_wdata_d  = '0;
                end
            end
            SERVE_I: begin
                if (mem_ready) begin
                    state_d    = RECOVER;
                    mem_read_d = 1'b0;
                    i_ready_d  = 1'b1;
                    i_rdata_d  = mem_rdata;
                end
            end
            SERVE_D: begin
                if (mem_ready) begin
                    state_d     = RECOVER;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    d_ready_d   = 1'b1;
                    // A write-back returns no data, so d_rdata keeps its value.
                    if (mem_read_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                i_ready_d = 1'b0;
                d_ready_d = 1'b0;
            end
        endcase

        // grant_d covers the RECOVER cycle that follows a D transaction.
        grant_d_d = (state_d == SERVE_D) ||
                    ((state_d == RECOVER) && (state_q == SERVE_D));
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            i_ready_q    <= 1'b0;
            i_rdata_q    <= '0;
            d_ready_q    <= 1'b0;
            d_rdata_q    <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            grant_d_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            i_ready_q    <= i_ready_d;
            i_rdata_q    <= i_rdata_d;
            d_ready_q    <= d_ready_d;
            d_rdata_q    <= d_rdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            grant_d_q    <= grant_d_d;
            busy_q       <= busy_d;
        end
    end

    assign i_ready   = i_ready_q;
    assign i_rdata   = i_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_rdata   = d_rdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign grant_d   = grant_d_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Directed testbench for mem_port_arbiter. Inputs are driven 1ns after each
// rising edge and outputs are observed at that same point, so every
// observation reflects the registers updated by the preceding edge.
// Expected values are written out per scenario. Compile with
// ARB_ROUND_ROBIN_EN defined to exercise the round-robin build.

`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;

    logic              clk;
    logic              rst_n;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic [DATA_W-1:0] i_rdata;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              grant_d;
    logic              busy;

    int passed;
    int total;

    logic [DATA_W-1:0] exp_d_rdata;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_read   (i_read),
        .i_addr   (i_addr),
        .i_ready  (i_ready),
        .i_rdata  (i_rdata),
        .d_read   (d_read),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ready  (d_ready),
        .d_rdata  (d_rdata),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .grant_d  (grant_d),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The two ready pulses and the two memory strobes must never overlap.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            total++;
            if ((i_ready && d_ready) || (mem_read && mem_write)) begin
                $display("[TB] FAIL exclusive: i_ready=%b d_ready=%b mem_read=%b mem_write=%b, required no overlap",
                         i_ready, d_ready, mem_read, mem_write);
            end else begin
                passed++;
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if ({i_ready, d_ready, mem_read, mem_write, grant_d, busy} !== 6'b0) begin
            $display("[TB] FAIL reset_flags: got %b, required 000000",
                     {i_ready, d_ready, mem_read, mem_write, grant_d, busy});
        end else passed++;
        total++;
        if (mem_addr !== '0 || mem_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
            $display("[TB] FAIL reset_data: mem_addr=%h mem_wdata=%h i_rdata=%h d_rdata=%h, required all 0",
                     mem_addr, mem_wdata, i_rdata, d_rdata);
        end else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_i_read();
        int strobe_cycles;
        strobe_cycles = 0;
        i_read = 1'b1;
        i_addr = 28'h0000010;
        tick();
        for (int c = 0; c < 3; c++) begin
            if (mem_read === 1'b1 && mem_write === 1'b0 && mem_addr === 28'h0000010 && grant_d === 1'b0)
                strobe_cycles++;
            if (c == 2) begin
                mem_ready = 1'b1;
                mem_rdata = {16{8'hA5}};
            end
            tick();
        end
        mem_ready = 1'b0;
        mem_rdata = '0;
        total++;
        if (strobe_cycles !== 3 || mem_read !== 1'b0) begin
            $display("[TB] FAIL i_read_strobe: cycles=%0d mem_read_after=%b, required 3 and 0",
                     strobe_cycles, mem_read);
        end else passed++;
        total++;
        if (i_ready !== 1'b1 || i_rdata !== {16{8'hA5}} || d_ready !== 1'b0 || busy !== 1'b1) begin
            $display("[TB] FAIL i_read_ready: i_ready=%b i_rdata=%h d_ready=%b busy=%b, required 1 a5..a5 0 1",
                     i_ready, i_rdata, d_ready, busy);
        end else passed++;
        tick();
        total++;
        if (i_ready !== 1'b0 || busy !== 1'b0 || d_ready !== 1'b0) begin
            $display("[TB] FAIL i_read_pulse: i_ready=%b busy=%b d_ready=%b, required 0 0 0",
                     i_ready, busy, d_ready);
        end else passed++;
        i_read = 1'b0;
        tick();
        total++;
        if (mem_read !== 1'b0 || busy !== 1'b0) begin
            $display("[TB] FAIL i_read_no_reserve: mem_read=%b busy=%b, required 0 0", mem_read, busy);
        end else passed++;
    endtask

    task automatic test_stray_ready();
        mem_ready = 1'b1;
        mem_rdata = {16{8'h3C}};
        tick();
        tick();
        total++;
        if ({i_ready, d_ready, mem_read, mem_write, busy} !== 5'b0 || i_rdata !== {16{8'hA5}}) begin
            $display("[TB] FAIL stray_ready: flags=%b i_rdata=%h, required 00000 a5..a5",
                     {i_ready, d_ready, mem_read, mem_write, busy}, i_rdata);
        end else passed++;
        mem_ready = 1'b0;
        mem_rdata = '0;
        tick();
    endtask

    task automatic test_simultaneous();
        logic              first_d;
        logic [ADDR_W-1:0] first_addr;
        logic [ADDR_W-1:0] second_addr;

        // Phase A: both requests pending out of reset; D must win in both builds.
        rst_n  = 1'b0;
        i_read = 1'b1;
        i_addr = 28'h0000030;
        d_read = 1'b1;
        d_addr = 28'h0000040;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000040 || grant_d !== 1'b1) begin
            $display("[TB] FAIL simul_first_d: mem_read=%b mem_addr=%h grant_d=%b, required 1 0000040 1",
                     mem_read, mem_addr, grant_d);
        end else passed++;
        mem_ready = 1'b1;
        mem_rdata = {16{8'hD1}};
        tick();
        mem_ready = 1'b0;
        total++;
        if (d_ready !== 1'b1 || d_rdata !== {16{8'hD1}} || i_ready !== 1'b0 || grant_d !== 1'b1) begin
            $display("[TB] FAIL simul_d_done: d_ready=%b d_rdata=%h i_ready=%b grant_d=%b, required 1 d1..d1 0 1",
                     d_ready, d_rdata, i_ready, grant_d);
        end else passed++;
        tick();
        d_read = 1'b0;
        total++;
        if (mem_read !== 1'b0 || busy !== 1'b0 || grant_d !== 1'b0) begin
            $display("[TB] FAIL simul_gap: mem_read=%b busy=%b grant_d=%b, required 0 0 0",
                     mem_read, busy, grant_d);
        end else passed++;
        tick();
        total++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000030 || grant_d !== 1'b0) begin
            $display("[TB] FAIL simul_then_i: mem_read=%b mem_addr=%h grant_d=%b, required 1 0000030 0",
                     mem_read, mem_addr, grant_d);
        end else passed++;
        mem_ready = 1'b1;
        mem_rdata = {16{8'hE0}};
        tick();
        mem_ready = 1'b0;
        total++;
        if (i_ready !== 1'b1 || i_rdata !== {16{8'hE0}}) begin
            $display("[TB] FAIL simul_i_done: i_ready=%b i_rdata=%h, required 1 e0..e0", i_ready, i_rdata);
        end else passed++;
        tick();
        i_read = 1'b0;

        // Phase B: a lone D transaction leaves last_grant at D, then both request.
        d_read = 1'b1;
        d_addr = 28'h0000050;
        tick();
        mem_ready = 1'b1;
        mem_rdata = {16{8'hD2}};
        tick();
        mem_ready = 1'b0;
        tick();
        d_addr = 28'h0000060;
        i_read = 1'b1;
        i_addr = 28'h0000070;
`ifdef ARB_ROUND_ROBIN_EN
        first_d     = 1'b0;
        first_addr  = 28'h0000070;
        second_addr = 28'h0000060;
        exp_d_rdata = {16{8'hE2}};
`else
        first_d     = 1'b1;
        first_addr  = 28'h0000060;
        second_addr = 28'h0000070;
        exp_d_rdata = {16{8'hE1}};
`endif
        tick();
        total++;
        if (mem_read !== 1'b1 || mem_addr !== first_addr || grant_d !== first_d) begin
            $display("[TB] FAIL arb_first: mem_read=%b mem_addr=%h grant_d=%b, required 1 %h %b",
                     mem_read, mem_addr, grant_d, first_addr, first_d);
        end else passed++;
        mem_ready = 1'b1;
        mem_rdata = {16{8'hE1}};
        tick();
        mem_ready = 1'b0;
        total++;
        if ({i_ready, d_ready} !== (first_d ? 2'b01 : 2'b10)) begin
            $display("[TB] FAIL arb_first_ready: i_ready,d_ready=%b, required %b",
                     {i_ready, d_ready}, (first_d ? 2'b01 : 2'b10));
        end else passed++;
        tick();
        if (first_d) d_read = 1'b0;
        else i_read = 1'b0;
        tick();
        total++;
        if (mem_read !== 1'b1 || mem_addr !== second_addr || grant_d !== ~first_d) begin
            $display("[TB] FAIL arb_second: mem_read=%b mem_addr=%h grant_d=%b, required 1 %h %b",
                     mem_read, mem_addr, grant_d, second_addr, ~first_d);
        end else passed++;
        mem_ready = 1'b1;
        mem_rdata = {16{8'hE2}};
        tick();
        mem_ready = 1'b0;
        total++;
        if ({i_ready, d_ready} !== (first_d ? 2'b10 : 2'b01) || d_rdata !== exp_d_rdata) begin
            $display("[TB] FAIL arb_second_ready: i_ready,d_ready=%b d_rdata=%h, required %b %h",
                     {i_ready, d_ready}, d_rdata, (first_d ? 2'b10 : 2'b01), exp_d_rdata);
        end else passed++;
        tick();
        i_read = 1'b0;
        d_read = 1'b0;
        tick();
    endtask

    task automatic test_d_write();
        d_write = 1'b1;
        d_addr  = 28'h0000200;
        d_wdata = 128'h1234;
        tick();
        for (int c = 0; c < 2; c++) begin
            total++;
            if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 28'h0000200 ||
                mem_wdata !== 128'h1234 || grant_d !== 1'b1) begin
                $display("[TB] FAIL d_write_hold: cycle=%0d mem_write=%b mem_read=%b mem_addr=%h mem_wdata=%h grant_d=%b, required 1 0 0000200 1234 1",
                         c, mem_write, mem_read, mem_addr, mem_wdata, grant_d);
            end else passed++;
            if (c == 1) begin
                mem_ready = 1'b1;
                mem_rdata = {16{8'hFF}};
            end
            tick();
        end
        mem_ready = 1'b0;
        mem_rdata = '0;
        total++;
        if (d_ready !== 1'b1 || mem_write !== 1'b0 || d_rdata !== exp_d_rdata || i_ready !== 1'b0) begin
            $display("[TB] FAIL d_write_done: d_ready=%b mem_write=%b d_rdata=%h i_ready=%b, required 1 0 %h 0",
                     d_ready, mem_write, d_rdata, i_ready, exp_d_rdata);
        end else passed++;
        tick();
        d_write = 1'b0;
        total++;
        if (d_ready !== 1'b0 || busy !== 1'b0) begin
            $display("[TB] FAIL d_write_pulse: d_ready=%b busy=%b, required 0 0", d_ready, busy);
        end else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        d_read = 1'b1;
        d_addr = 28'h0000100;
        tick();
        mem_ready = 1'b1;
        mem_rdata = {16{8'hB1}};
        tick();
        mem_ready = 1'b0;
        total++;
        if (d_ready !== 1'b1 || d_rdata !== {16{8'hB1}} || busy !== 1'b1 || mem_read !== 1'b0) begin
            $display("[TB] FAIL b2b_first: d_ready=%b d_rdata=%h busy=%b mem_read=%b, required 1 b1..b1 1 0",
                     d_ready, d_rdata, busy, mem_read);
        end else passed++;
        tick();
        d_addr = 28'h0000110;
        total++;
        if (mem_read !== 1'b0 || busy !== 1'b0 || d_ready !== 1'b0) begin
            $display("[TB] FAIL b2b_gap: mem_read=%b busy=%b d_ready=%b, required 0 0 0",
                     mem_read, busy, d_ready);
        end else passed++;
        tick();
        total++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000110) begin
            $display("[TB] FAIL b2b_second: mem_read=%b mem_addr=%h, required 1 0000110", mem_read, mem_addr);
        end else passed++;
        mem_ready = 1'b1;
        mem_rdata = {16{8'hB2}};
        tick();
        mem_ready = 1'b0;
        total++;
        if (d_ready !== 1'b1 || d_rdata !== {16{8'hB2}}) begin
            $display("[TB] FAIL b2b_second_done: d_ready=%b d_rdata=%h, required 1 b2..b2", d_ready, d_rdata);
        end else passed++;
        tick();
        d_read = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_serve();
        i_read = 1'b1;
        i_addr = 28'h0000300;
        tick();
        total++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000300) begin
            $display("[TB] FAIL rst_mid_start: mem_read=%b mem_addr=%h, required 1 0000300", mem_read, mem_addr);
        end else passed++;
        tick();
        rst_n  = 1'b0;
        i_read = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if ({i_ready, d_ready, mem_read, mem_write, grant_d, busy} !== 6'b0 ||
            mem_addr !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
            $display("[TB] FAIL rst_mid_clear: flags=%b mem_addr=%h i_rdata=%h d_rdata=%h, required all 0",
                     {i_ready, d_ready, mem_read, mem_write, grant_d, busy}, mem_addr, i_rdata, d_rdata);
        end else passed++;
        tick();
        total++;
        if (i_ready !== 1'b0 || busy !== 1'b0 || mem_read !== 1'b0) begin
            $display("[TB] FAIL rst_mid_abandon: i_ready=%b busy=%b mem_read=%b, required 0 0 0",
                     i_ready, busy, mem_read);
        end else passed++;
        i_read = 1'b1;
        i_addr = 28'h0000310;
        tick();
        total++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000310 || busy !== 1'b1) begin
            $display("[TB] FAIL rst_mid_fresh: mem_read=%b mem_addr=%h busy=%b, required 1 0000310 1",
                     mem_read, mem_addr, busy);
        end else passed++;
        mem_ready = 1'b1;
        mem_rdata = {16{8'hC3}};
        tick();
        mem_ready = 1'b0;
        total++;
        if (i_ready !== 1'b1 || i_rdata !== {16{8'hC3}}) begin
            $display("[TB] FAIL rst_mid_fresh_done: i_ready=%b i_rdata=%h, required 1 c3..c3", i_ready, i_rdata);
        end else passed++;
        tick();
        i_read = 1'b0;
        tick();
    endtask

    initial begin
        passed      = 0;
        total       = 0;
        exp_d_rdata = '0;
        rst_n       = 1'b0;
        i_read      = 1'b0;
        i_addr      = '0;
        d_read      = 1'b0;
        d_write     = 1'b0;
        d_addr      = '0;
        d_wdata     = '0;
        mem_ready   = 1'b0;
        mem_rdata   = '0;

        test_reset();
        test_i_read();
        test_stray_ready();
        test_simultaneous();
        test_d_write();
        test_back_to_back();
        test_reset_mid_serve();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the I-cache refill path, which feeds the fetch stage, and the D-cache refill/write-back path.
- Registered FSM: accepts one line-sized transaction at a time, holds memory-side signals stable until mem_ready, then returns data and a one-cycle ready pulse to the winning requester.
- Sits between both caches and the off-chip memory model; the fetch stage's memory_stall derives from the caches waiting on this block.

Parameters:
ADDR_W, 28, line address width (byte address bits [31:4])
DATA_W, 128, line width in bits

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
i_read  input  1  I-cache line read request; held until i_ready
i_addr  input  ADDR_W  I-cache line address
i_ready  output  1  one-cycle pulse: I transaction complete, i_rdata valid
i_rdata  output  DATA_W  line returned to I-cache
d_read  input  1  D-cache line read request; held until d_ready
d_write  input  1  D-cache line write request; held until d_ready
d_addr  input  ADDR_W  D-cache line address
d_wdata  input  DATA_W  D-cache write-back line
d_ready  output  1  one-cycle pulse: D transaction complete (d_rdata valid for reads)
d_rdata  output  DATA_W  line returned to D-cache
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_addr  output  ADDR_W  memory line address
mem_wdata  output  DATA_W  memory write data
mem_ready  input  1  memory completion; mem_rdata valid when high on a read
mem_rdata  input  DATA_W  memory read data
grant_d  output  1  1 while D owns the port (SERVE_D/RECOVER after D), else 0
busy  output  1  1 in any state other than IDLE

Behaviour:
- All outputs registered. Reset values: every output 0, state IDLE, last_grant=I.
- States: IDLE, SERVE_I, SERVE_D, RECOVER.
- IDLE:
  - d_read|d_write high -> latch d_addr, d_wdata and op (write if d_write, else read); go to SERVE_D.
  - Else i_read high -> latch i_addr; go to SERVE_I.
  - Else stay in IDLE.
- Entering SERVE_x, same edge: mem_addr/mem_wdata from latched values; mem_read or mem_write set per op. mem_wdata=0 for reads.
- Latency: request first seen in IDLE at edge N -> memory strobe high after edge N.
- SERVE_x: memory outputs held constant while mem_ready=0, no cycle limit.
  - When mem_ready=1 at edge M: mem_read/mem_write cleared; x_rdata<=mem_rdata (reads only; write leaves x_rdata unchanged); x_ready<=1; go to RECOVER.
- RECOVER: exactly one cycle.
  - x_ready is high during this cycle; it clears at the next edge.
  - Return to IDLE. The requester drops its request at that same edge, so a completed request is never re-served.
- Next grant is possible at edge M+2; its memory strobe is visible after M+2.
- i_ready and d_ready are never high in the same cycle; at most one strobe is high at any time.
- Simultaneous d_read and d_write: treated as a write.
- Requests arriving while not IDLE are ignored until IDLE. Requesters must hold them, and their address/data are sampled only in IDLE.
- mem_ready outside SERVE_x is ignored.
- Reset asserted mid-transaction: return to IDLE with all outputs 0 at that edge; the in-flight memory access is abandoned, with no ready pulse to either requester.
- last_grant updates on every IDLE->SERVE_x transition.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when d and i requests are both pending in IDLE, grant the side not equal to last_grant. Single requests are granted immediately regardless of last_grant.
- Undefined: fixed priority, D over I; last_grant is still tracked but unused.

Test Plan:
- Isolated I read: i_read=1, i_addr=28'h0000010; mem_ready high 3 cycles after mem_read, mem_rdata=128'hA5..A5 -> mem_read high exactly 3 cycles with mem_addr=28'h0000010; i_ready one-cycle pulse with i_rdata=128'hA5..A5; d_ready stays 0.
- D write-back: d_write=1, d_addr=28'h0000200, d_wdata=128'h1234 -> mem_write high, mem_read 0, mem_wdata=128'h1234 until mem_ready; d_ready pulse one cycle later; d_rdata unchanged.
- Simultaneous: i_read and d_read both asserted from reset, no macro -> D served first, then I starts 2 cycles after D's mem_ready. With ARB_ROUND_ROBIN_EN and last_grant=D -> I first.
- Back-to-back from the same requester: d_read held, reasserted right after d_ready -> exactly one RECOVER cycle separates transactions; no duplicate mem_read for the first address.
- Reset mid-SERVE_I: rst_n=0 for one edge while mem_read=1 -> all outputs 0 next cycle, no i_ready, busy=0; fresh i_read afterwards completes normally.
- Stray mem_ready=1 in IDLE with no requests -> no ready pulse, state stays IDLE.
